// File: rtl/alu_pkg.sv
// Shared constants for the bit-serial ALU: cell op codes, full alu_ctl codes,
// alu_ctl field positions and the sequencer state encoding.
package alu_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  localparam int CTL_A_INV  = 3;
  localparam int CTL_B_INV  = 2;
  localparam int CTL_OP_MSB = 1;
  localparam int CTL_OP_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_cell.sv
// One-bit ALU slice: optional operand inversion, AND/OR/full-add/less select.
// The adder carry-out is produced regardless of the selected op.
module alu_cell
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       ci_i,
  input  logic       less_i,
  input  logic       a_invert_i,
  input  logic       b_invert_i,
  input  logic [1:0] op_i,
  output logic       result_o,
  output logic       co_o
);

  logic aa;
  logic bb;
  logic sum;

  always_comb begin
    aa   = a_i ^ a_invert_i;
    bb   = b_i ^ b_invert_i;
    sum  = aa ^ bb ^ ci_i;
    co_o = (aa & bb) | (aa & ci_i) | (bb & ci_i);
    case (op_i)
      OP_AND:  result_o = aa & bb;
      OP_OR:   result_o = aa | bb;
      OP_ADD:  result_o = sum;
      default: result_o = less_i;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial WIDTH-bit ALU sequencer driving a single alu_cell, LSB first.
// Define ALU_SERIAL_ABORT_EN to add an abort input that cancels RUN/FIX.
//
// state | meaning
// IDLE  | ready=1, waiting for start
// RUN   | one operand bit per cycle through alu_cell
// FIX   | SLT only: result becomes corrected sign bit
// DONE  | valid pulse; result/zero/overflow already final
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_SERIAL_ABORT_EN
  input  logic             abort,
`endif
  output logic             ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             valid
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] a_sh_q,     a_sh_d;
  logic [WIDTH-1:0] b_sh_q,     b_sh_d;
  logic [WIDTH-1:0] work_q,     work_d;
  logic [3:0]       ctl_q,      ctl_d;
  logic             carry_q,    carry_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic             sign_q,     sign_d;
  logic             ovf_q,      ovf_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             zero_q,     zero_d;
  logic             overflow_q, overflow_d;

  logic       cell_res;
  logic       cell_co;
  logic [1:0] cell_op;
  logic       is_slt;
  logic       is_addsub;
  logic       slt_bit;

  // SLT reuses the subtract path; the sign is turned into the answer in FIX.
  assign is_slt    = (ctl_q[CTL_OP_MSB:CTL_OP_LSB] == OP_LESS);
  assign cell_op   = is_slt ? OP_ADD : ctl_q[CTL_OP_MSB:CTL_OP_LSB];
  assign is_addsub = (ctl_q == CTL_ADD) || (ctl_q == CTL_SUB);
  assign slt_bit   = sign_q ^ ovf_q;

  alu_cell u_cell (
    .a_i        (a_sh_q[0]),
    .b_i        (b_sh_q[0]),
    .ci_i       (carry_q),
    .less_i     (1'b0),
    .a_invert_i (ctl_q[CTL_A_INV]),
    .b_invert_i (ctl_q[CTL_B_INV]),
    .op_i       (cell_op),
    .result_o   (cell_res),
    .co_o       (cell_co)
  );

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    work_d     = work_q;
    ctl_d      = ctl_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    ready      = 1'b0;
    valid      = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          ctl_d   = alu_ctl;
          carry_d = alu_ctl[CTL_B_INV];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = cell_co;
        work_d  = {cell_res, work_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sign_d = cell_res;
          ovf_d  = carry_q ^ cell_co;
          if (is_slt) begin
            state_d = FIX;
          end else begin
            // Outputs are loaded on entry to DONE so they are final with valid.
            result_d   = work_d;
            zero_d     = (work_d == '0);
            overflow_d = is_addsub & (carry_q ^ cell_co);
            state_d    = DONE;
          end
        end
      end
      FIX: begin
        result_d   = {{(WIDTH-1){1'b0}}, slt_bit};
        zero_d     = ~slt_bit;
        overflow_d = 1'b0;
        state_d    = DONE;
      end
      DONE: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef ALU_SERIAL_ABORT_EN
    if (abort && (state_q == RUN || state_q == FIX)) begin
      state_d    = IDLE;
      result_d   = result_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      work_q     <= '0;
      ctl_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      work_q     <= work_d;
      ctl_q      <= ctl_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule
